// File: rtl/mux_n1_rr.sv
// mux_n1_rr: parametrised N:1 registered multiplexer with valid/ready on both sides.
// Selection is either fixed (external sel) or round-robin (internal rotating pointer).
// The chosen word is registered into a single output slot. The slot reloads in the
// same cycle it drains, so the block sustains one word per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   mode       0 = fixed select via sel, 1 = round-robin
//   sel        channel index used when mode = 0
//   in_data    packed inputs; channel k occupies bits [k*WIDTH +: WIDTH]
//   in_valid   per-channel word available
//   in_ready   per-channel accept; one-hot or zero; combinational
//   out_data   registered selected word
//   out_chan   index of the channel out_data came from
//   out_valid  output slot holds a word
//   out_ready  downstream accepts the word
module mux_n1_rr #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0]    out_data_q,  out_data_d;
    logic [SELW-1:0]     out_chan_q,  out_chan_d;
    logic                out_valid_q, out_valid_d;
    logic [SELW-1:0]     ptr_q,       ptr_d;

    logic                load_s;
    logic                sel_valid_s;
    logic                grant_valid_s;
    logic [SELW-1:0]     grant_s;
    logic [CHANNELS-1:0] in_ready_s;
    logic [WIDTH-1:0]    grant_word_s;
    logic                xfer_s;

    // Grant arbitration: fixed select or first valid channel at or after the pointer.
    always_comb begin
        sel_valid_s   = 1'b0;
        grant_valid_s = 1'b0;
        grant_s       = {SELW{1'b0}};
        // An out-of-range sel matches no channel, so it never yields a grant.
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel == SELW'(k)) begin
                sel_valid_s = in_valid[k];
            end else begin
                sel_valid_s = sel_valid_s;
            end
        end
        case (mode)
            1'b0: begin
                if (sel_valid_s) begin
                    grant_valid_s = 1'b1;
                    grant_s       = sel;
                end else begin
                    grant_valid_s = 1'b0;
                end
            end
            1'b1: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    int idx;
                    idx = (int'(ptr_q) + i) % CHANNELS;
                    if (!grant_valid_s && in_valid[idx]) begin
                        grant_valid_s = 1'b1;
                        grant_s       = SELW'(idx);
                    end else begin
                        grant_valid_s = grant_valid_s;
                    end
                end
            end
            default: begin
                grant_valid_s = 1'b0;
            end
        endcase
    end

    // Handshake decode: one-hot accept on the granted channel when the slot can load.
    always_comb begin
        load_s       = !out_valid_q || out_ready;
        in_ready_s   = {CHANNELS{1'b0}};
        grant_word_s = {WIDTH{1'b0}};
        for (int k = 0; k < CHANNELS; k++) begin
            // rst gating keeps every in_ready low while the block is held in reset.
            in_ready_s[k] = !rst && load_s && grant_valid_s && (grant_s == SELW'(k));
            if (grant_s == SELW'(k)) begin
                grant_word_s = in_data[k*WIDTH +: WIDTH];
            end else begin
                grant_word_s = grant_word_s;
            end
        end
        xfer_s = |(in_ready_s & in_valid);
    end

    // Next-state for the output slot and round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer_s) begin
            out_data_d  = grant_word_s;
            out_chan_d  = grant_s;
            out_valid_d = 1'b1;
            if (mode) begin
                ptr_d = (grant_s == SELW'(CHANNELS - 1)) ? {SELW{1'b0}} : grant_s + 1'b1;
            end else begin
                ptr_d = ptr_q;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= {WIDTH{1'b0}};
            out_chan_q  <= {SELW{1'b0}};
            out_valid_q <= 1'b0;
            ptr_q       <= {SELW{1'b0}};
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_n1_rr.sv
// Testbench for mux_n1_rr: directed steps followed by random traffic, all checked
// against a transaction-level reference model (slot contents, pointer, grant rule).
// A second CHANNELS=3 instance covers an out-of-range select.
module tb_mux_n1_rr;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           mode = 1'b0;
    logic [1:0]     sel = 2'd0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_chan;
    logic           out_valid;
    logic           out_ready = 1'b0;

    logic           mode3 = 1'b0;
    logic [1:0]     sel3 = 2'd3;
    logic [3*W-1:0] in_data3 = 24'hC3B2A1;
    logic [2:0]     in_valid3 = 3'b111;
    logic [2:0]     in_ready3;
    logic [W-1:0]   out_data3;
    logic [1:0]     out_chan3;
    logic           out_valid3;
    logic           out_ready3 = 1'b1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int       m_ptr  = 0;
    logic     m_valid = 1'b0;
    logic [W-1:0] m_data = '0;
    int       m_chan = 0;

    mux_n1_rr #(.WIDTH(W), .CHANNELS(N)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_n1_rr #(.WIDTH(W), .CHANNELS(3)) dut3 (
        .clk(clk), .rst(rst), .mode(mode3), .sel(sel3), .in_data(in_data3),
        .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
        .out_chan(out_chan3), .out_valid(out_valid3), .out_ready(out_ready3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Which channel the rules grant right now, or -1.
    function automatic int model_grant();
        if (mode == 1'b0) begin
            if (int'(sel) < N && in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int i = 0; i < N; i++) begin
            int c;
            c = (m_ptr + i) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_valid = 1'b0; m_data = '0; m_chan = 0;
    endtask

    // One clock: check combinational accept, clock, update model, check slot.
    task automatic step(input string tag);
        int  g;
        logic load;
        logic [N-1:0] exp_rdy;
        #1;
        g = model_grant();
        load = !m_valid || out_ready;
        exp_rdy = (load && g >= 0) ? N'(1 << g) : '0;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (load && g >= 0) begin
            m_valid = 1'b1;
            m_data  = in_data[g*W +: W];
            m_chan  = g;
            if (mode) m_ptr = (g + 1) % N;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".out_data"},  32'(out_data),  32'(m_data));
        chk({tag, ".out_chan"},  32'(out_chan),  32'(m_chan));
    endtask

    initial begin
        logic [1:0] rr_exp [6];
        rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        // Power-on reset with traffic present
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        #12;
        chk("por.out_valid", 32'(out_valid), 32'd0);
        chk("por.in_ready", 32'(in_ready), 32'd0);
        chk("por3.in_ready", 32'(in_ready3), 32'd0);
        @(negedge clk); rst = 1'b0; model_reset();

        // Fixed-mode sweep
        mode = 1'b0; in_data = 32'h44332211; in_valid = 4'b1111; out_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            step("fixed");
            chk("fixed.data_const", 32'(out_data), 32'(8'h11 * (s + 1)));
            chk("fixed.chan_const", 32'(out_chan), 32'(s));
        end

        // Round-robin rotation and wrap; pointer still 0 after fixed mode
        mode = 1'b1;
        for (int s = 0; s < 6; s++) begin
            step("rr");
            chk("rr.chan_seq", 32'(out_chan), 32'(rr_exp[s]));
            chk("rr.valid_cont", 32'(out_valid), 32'd1);
        end

        // Round-robin skip: bring ptr to 1, then only channels 0 and 3 valid
        in_valid = 4'b0001; step("rr_setup");
        in_valid = 4'b1001;
        step("rr_skip1"); chk("rr_skip.first", 32'(out_chan), 32'd3);
        step("rr_skip2"); chk("rr_skip.second", 32'(out_chan), 32'd0);

        // Backpressure: hold 0x22 for three cycles, then reload with no bubble
        mode = 1'b0; sel = 2'd1; in_valid = 4'b1111;
        step("bp_load"); chk("bp.loaded", 32'(out_data), 32'h22);
        out_ready = 1'b0;
        in_data = 32'h44339911;
        for (int s = 0; s < 3; s++) begin
            step("bp_stall");
            chk("bp.stable", 32'(out_data), 32'h22);
        end
        out_ready = 1'b1;
        step("bp_release");
        chk("bp.no_bubble_valid", 32'(out_valid), 32'd1);
        chk("bp.no_bubble_data", 32'(out_data), 32'h99);

        // Selected channel not valid: no transfer, slot drains
        sel = 2'd2; in_valid = 4'b1011;
        step("nogrant1"); chk("nogrant.drained", 32'(out_valid), 32'd0);
        step("nogrant2");

        // Mid-operation asynchronous reset with 0x5A held under stall
        sel = 2'd0; in_data = 32'h4433225A; in_valid = 4'b1111; out_ready = 1'b0;
        step("pre_rst"); chk("pre_rst.data", 32'(out_data), 32'h5A);
        #2 rst = 1'b1;
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_data", 32'(out_data), 32'd0);
        chk("rst.out_chan", 32'(out_chan), 32'd0);
        out_ready = 1'b1; #1;
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        @(negedge clk); rst = 1'b0; model_reset();

        // Random traffic against the model
        for (int s = 0; s < 400; s++) begin
            mode      = 1'($urandom);
            sel       = 2'($urandom);
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            step("rand");
        end

        // CHANNELS=3 build: sel=3 never grants, sel=2 does
        chk("n3.sel3_ready", 32'(in_ready3), 32'd0);
        chk("n3.sel3_valid", 32'(out_valid3), 32'd0);
        sel3 = 2'd2; #1;
        chk("n3.sel2_ready", 32'(in_ready3), 32'b100);
        @(posedge clk); #1;
        chk("n3.sel2_valid", 32'(out_valid3), 32'd1);
        chk("n3.sel2_chan", 32'(out_chan3), 32'd2);
        chk("n3.sel2_data", 32'(out_data3), 32'hC3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
